// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register offsets,
// register bit positions and the deserialiser state encoding.
package uart_pkg;

  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;

  localparam int CTRL_RX_EN   = 0;
  localparam int CTRL_IRQ_EN  = 1;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO. A push into a full FIFO is accepted only when a
// pop retires the head in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy are control state.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: serial deserialiser feeding an RX FIFO,
// with RXDATA/STATUS/CTRL registers on the data bus and a level interrupt.
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iCE,
  input  logic        iRD,
  input  logic        iWR,
  input  logic [31:0] iADDR,
  input  logic [31:0] iDATA,
  output logic [31:0] oDATA,
  input  logic        iRXD,
  output logic        oIRQ
);

  localparam int TW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(BAUD_DIV / 2 - 1);

  function automatic logic [3:0] sat_count(input logic [CW-1:0] c);
    if (32'(c) > 15) return 4'hF;
    return 4'(c);
  endfunction

  logic          rxd_meta_p0;
  logic          rxd_sync_p1;
  logic          rxd_prev_p2;
  logic          rx_fall;
  rx_state_e     state;
  logic [TW-1:0] bit_tmr;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_push;
  logic          ferr_set;

  logic [1:0]    ctrl;
  logic          overrun;
  logic          frame_err;

  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic [1:0]    reg_sel;
  logic          bus_rd;
  logic          bus_wr;
  logic          sts_wr;
  logic          rd_pop;
  logic          ovr_set;
  logic [31:0]   status_w;
  logic [31:0]   rdata_c;
  logic          unused_bits;

  assign reg_sel     = iADDR[3:2];
  assign bus_rd      = iCE & iRD;
  assign bus_wr      = iCE & iWR;
  assign sts_wr      = bus_wr & (reg_sel == REG_STATUS);
  assign rd_pop      = bus_rd & (reg_sel == REG_RXDATA) & ~fifo_empty;
  assign ovr_set     = rx_push & fifo_full & ~rd_pop;
  assign rx_fall     = rxd_prev_p2 & ~rxd_sync_p1;
  assign unused_bits = ^{iADDR[31:4], iADDR[1:0], iDATA[31:4]};

  assign status_w = {24'b0, sat_count(fifo_count), frame_err, overrun,
                     fifo_full, ~fifo_empty};

  // Stage boundary: two-flop synchroniser plus one history flop for edge detect.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rxd_meta_p0 <= 1'b1;
      rxd_sync_p1 <= 1'b1;
      rxd_prev_p2 <= 1'b1;
    end else begin
      rxd_meta_p0 <= iRXD;
      rxd_sync_p1 <= rxd_meta_p0;
      rxd_prev_p2 <= rxd_sync_p1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state    <= RX_IDLE;
      bit_tmr  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_push  <= 1'b0;
      ferr_set <= 1'b0;
    end else begin
      rx_push  <= 1'b0;
      ferr_set <= 1'b0;
      if (!ctrl[CTRL_RX_EN]) begin
        state   <= RX_IDLE;
        bit_tmr <= '0;
      end else begin
        case (state)
          RX_IDLE: begin
            bit_tmr <= '0;
            if (rx_fall) state <= RX_START;
          end
          RX_START: begin
            if (bit_tmr == HALF_LAST) begin
              bit_tmr <= '0;
              bit_idx <= '0;
              state   <= rxd_sync_p1 ? RX_IDLE : RX_DATA;
            end else begin
              bit_tmr <= bit_tmr + 1'b1;
            end
          end
          RX_DATA: begin
            if (bit_tmr == BIT_LAST) begin
              bit_tmr <= '0;
              shift   <= {rxd_sync_p1, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= RX_STOP;
            end else begin
              bit_tmr <= bit_tmr + 1'b1;
            end
          end
          RX_STOP: begin
            if (bit_tmr == BIT_LAST) begin
              bit_tmr  <= '0;
              state    <= RX_IDLE;
              rx_push  <= rxd_sync_p1;
              ferr_set <= ~rxd_sync_p1;
            end else begin
              bit_tmr <= bit_tmr + 1'b1;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk       (iCLK),
    .rst_n     (iRST),
    .push      (rx_push),
    .push_data (shift),
    .pop       (rd_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Read data is taken from pre-write state so a combined read/write
  // returns the old register contents.
  always_comb begin
    rdata_c = '0;
    case (reg_sel)
      REG_RXDATA: if (!fifo_empty) rdata_c = {24'b0, fifo_head};
      REG_STATUS: rdata_c = status_w;
      REG_CTRL:   rdata_c = {30'b0, ctrl};
      default:    rdata_c = '0;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDATA     <= '0;
      ctrl      <= 2'b01;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      oIRQ      <= 1'b0;
    end else begin
      if (bus_rd) oDATA <= rdata_c;
      if (bus_wr && reg_sel == REG_CTRL) ctrl <= iDATA[1:0];
      overrun   <= ovr_set  | (overrun   & ~(sts_wr & iDATA[ST_OVERRUN]));
      frame_err <= ferr_set | (frame_err & ~(sts_wr & iDATA[ST_FRAME_ERR]));
      oIRQ      <= ctrl[CTRL_IRQ_EN] & (~fifo_empty | overrun | frame_err);
    end
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Scoreboard bench for uart_rx_mmio: frames are driven on iRXD, register reads
// push expected data from a queue-based model, a monitor compares oDATA.
module tb_uart_rx_mmio;

  localparam int BAUD  = 16;
  localparam int DEPTH = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce    = 1'b0;
  logic        rd    = 1'b0;
  logic        wr    = 1'b0;
  logic        rxd   = 1'b1;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  uart_rx_mmio #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .iCLK(clk), .iRST(rst_n), .iCE(ce), .iRD(rd), .iWR(wr),
    .iADDR(addr), .iDATA(wdata), .oDATA(rdata), .iRXD(rxd), .oIRQ(irq)
  );

  always #5 clk = ~clk;

  string       exp_name_q[$];
  logic [31:0] exp_val_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  bit          rd_seen = 1'b0;

  logic [7:0]  m_fifo[$];
  bit          m_ovr   = 1'b0;
  bit          m_ferr  = 1'b0;
  logic [1:0]  m_ctrl  = 2'b01;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  always @(posedge clk) rd_seen <= ce & rd;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_val_q.size() == 0) begin
        n_total++;
        $display("FAIL stray_read: got 0x%08h expected no read data", rdata);
      end else begin
        check(exp_name_q.pop_front(), rdata, exp_val_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] m_status();
    int c = m_fifo.size();
    return {24'b0, 4'(c > 15 ? 15 : c), m_ferr, m_ovr, c == DEPTH, c != 0};
  endfunction

  function automatic logic m_irq();
    return m_ctrl[1] & ((m_fifo.size() != 0) | m_ovr | m_ferr);
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] v = '0;
    case (a)
      2'd0: if (m_fifo.size() > 0) v = {24'b0, m_fifo.pop_front()};
      2'd1: v = m_status();
      2'd2: v = {30'b0, m_ctrl};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic void m_write(input logic [1:0] a, input logic [31:0] d);
    if (a == 2'd2) m_ctrl = d[1:0];
    if (a == 2'd1) begin
      if (d[2]) m_ovr = 1'b0;
      if (d[3]) m_ferr = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [1:0] a, input string nm);
    exp_name_q.push_back(nm);
    exp_val_q.push_back(m_read(a));
    ce = 1'b1; rd = 1'b1; addr = {28'b0, a, 2'b00};
    tick();
    ce = 1'b0; rd = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    m_write(a, d);
    ce = 1'b1; wr = 1'b1; addr = {28'b0, a, 2'b00}; wdata = d;
    tick();
    ce = 1'b0; wr = 1'b0;
  endtask

  task automatic do_rdwr(input logic [1:0] a, input logic [31:0] d, input string nm);
    exp_name_q.push_back(nm);
    exp_val_q.push_back(m_read(a));
    m_write(a, d);
    ce = 1'b1; rd = 1'b1; wr = 1'b1; addr = {28'b0, a, 2'b00}; wdata = d;
    tick();
    ce = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  // One 8N1 frame, LSB first; the model is updated once the line is idle again.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    rxd = 1'b0;
    repeat (BAUD) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BAUD) tick();
    end
    rxd = stop_ok;
    repeat (BAUD) tick();
    rxd = 1'b1;
    repeat (4) tick();
    if (m_ctrl[0]) begin
      if (!stop_ok) m_ferr = 1'b1;
      else if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic drain(input string nm);
    while (m_fifo.size() > 0) do_read(2'd0, nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("rst_odata", rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    do_read(2'd1, "status_reset");
    do_read(2'd2, "ctrl_reset");
    do_read(2'd3, "reserved");

    send_frame(8'hA5, 1'b1);
    do_read(2'd1, "status_one");
    do_read(2'd0, "rx_a5");
    do_read(2'd1, "status_empty");
    do_read(2'd0, "rx_empty");

    do_rdwr(2'd2, 32'h3, "ctrl_rdwr_old");
    do_read(2'd2, "ctrl_new");
    do_write(2'd2, 32'h1);

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    do_read(2'd1, "status_overrun");
    drain("rx_seq");
    do_read(2'd1, "status_ovr_only");
    do_write(2'd1, 32'h4);
    do_read(2'd1, "status_ovr_clr");

    do_write(2'd2, 32'h3);
    send_frame(8'h3C, 1'b0);
    check("irq_ferr", {31'b0, irq}, {31'b0, m_irq()});
    do_read(2'd1, "status_ferr");
    do_write(2'd1, 32'h8);
    tick();
    check("irq_cleared", {31'b0, irq}, {31'b0, m_irq()});
    do_write(2'd2, 32'h1);

    rxd = 1'b0;
    repeat (4) tick();
    rxd = 1'b1;
    repeat (30) tick();
    do_read(2'd1, "status_glitch");
    send_frame(8'h5A, 1'b1);
    do_read(2'd0, "rx_5a");

    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1);
    fork
      send_frame(8'($urandom), 1'b1);
      begin
        bit got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
          @(negedge clk);
          if (dut.rx_push) got = 1'b1;
        end
        if (got) begin
          exp_name_q.push_back("rx_pop_on_push");
          exp_val_q.push_back(m_read(2'd0));
          ce = 1'b1; rd = 1'b1; addr = 32'h0;
          tick();
          ce = 1'b0; rd = 1'b0;
        end else begin
          n_total++;
          $display("FAIL push_wait: got no push within 400 cycles expected one push");
        end
      end
    join
    do_read(2'd1, "status_full_pop");
    drain("rx_full_pop");

    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (60) tick();
        do_write(2'd2, 32'h0);
      end
    join
    do_write(2'd2, 32'h1);
    do_read(2'd1, "status_abort");

    for (int i = 0; i < 6; i++) begin
      logic [7:0] b = 8'($urandom);
      bit stop_ok = ($urandom_range(0, 4) != 0);
      send_frame(b, stop_ok);
      case ($urandom_range(0, 2))
        0: do_read(2'd0, "rx_rand");
        1: do_read(2'd1, "status_rand");
        default: ;
      endcase
    end
    do_read(2'd1, "status_rand_end");
    do_write(2'd1, 32'hC);
    drain("rx_rand_drain");
    do_read(2'd1, "status_final");

    repeat (5) tick();
    n_total++;
    if (exp_val_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending reads expected 0", exp_val_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
